// File: rtl/core_pipe_decode_pkg.sv
// Shared decode-stage types and constants: widths, RV base opcodes, s2 payload layout.
// Latency: n/a (package).
// Backpressure: n/a (package).
package core_pipe_decode_pkg;

    localparam int XL         = 64;  // default address / PC width
    localparam int FD_IBUF_R  = 32;  // instruction window width from fetch
    localparam int FD_ERR_R   = 2;   // fetch error tags, one per halfword
    localparam int REG_ADDR_R = 5;   // architectural register address width

    // Major opcodes, instr[6:2] of a 32-bit encoding
    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_AMO       = 5'b01011;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    // Decoded payload carried in the s2 pipeline register (PC kept separately
    // because its width follows the top-level parameter).
    typedef struct packed {
        logic [FD_IBUF_R-1:0]  instr;
        logic                  size32;
        logic [REG_ADDR_R-1:0] rs1;
        logic [REG_ADDR_R-1:0] rs2;
        logic [REG_ADDR_R-1:0] rd;
        logic                  trap_ferr;
        logic                  trap_ill;
    } dec_t;

    // True when a 32-bit major opcode belongs to the supported base set.
    function automatic logic opc_legal(input logic [4:0] opc);
        return opc inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC,
                           OPC_OP_IMM_32, OPC_STORE, OPC_AMO, OPC_OP, OPC_LUI,
                           OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/core_pipe_decode_fields.sv
// Combinational field extraction: instruction size, register addresses, fetch/illegal traps.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; results are only meaningful when the caller accepts s1.
module core_pipe_decode_fields
    import core_pipe_decode_pkg::*;
(
    input  logic [FD_IBUF_R-1:0]  s1_instr,
    input  logic [FD_ERR_R-1:0]   s1_ferr,
    output logic                  is32,
    output logic [REG_ADDR_R-1:0] rs1,
    output logic [REG_ADDR_R-1:0] rs2,
    output logic [REG_ADDR_R-1:0] rd,
    output logic                  trap_ferr,
    output logic                  trap_ill
);

    // Size, register fields and traps; a faulted low halfword is never trusted as a 32-bit prefix
    always_comb begin
        is32      = (s1_instr[1:0] == 2'b11) && !s1_ferr[0];
        rs1       = '0;
        rs2       = '0;
        rd        = '0;
        trap_ferr = 1'b0;
        trap_ill  = 1'b0;

        if (is32) begin
            rd        = s1_instr[11:7];
            rs1       = s1_instr[19:15];
            rs2       = s1_instr[24:20];
            trap_ferr = |s1_ferr;
            trap_ill  = !opc_legal(s1_instr[6:2]);
        end else begin
            trap_ferr = s1_ferr[0];
            trap_ill  = (s1_instr[15:0] == 16'h0000);
            if (s1_instr[1:0] == 2'b10) begin
                // quadrant 2 uses full 5-bit register specifiers
                rd  = s1_instr[11:7];
                rs1 = s1_instr[11:7];
                rs2 = s1_instr[6:2];
            end else begin
                // quadrants 0/1 use the compressed x8..x15 window
                rd  = {2'b01, s1_instr[9:7]};
                rs1 = {2'b01, s1_instr[9:7]};
                rs2 = {2'b01, s1_instr[4:2]};
            end
        end

        // a fetch fault makes the encoding meaningless, so it is not also illegal
        if (trap_ferr) begin
            trap_ill = 1'b0;
        end
    end

endmodule

// File: rtl/core_pipe_decode.sv
// Decode stage: owns the fetch PC, drains fetch by 2/4 bytes, registers decoded instr for execute.
// Latency: 1 cycle from accept to s2_valid; full throughput while s2_ready is high.
// Backpressure: single-entry valid/ready register; no eat and PC hold while s2 is stalled.
module core_pipe_decode
    import core_pipe_decode_pkg::*;
#(
    parameter int               XLEN             = XL,
    parameter logic [XLEN-1:0]  PC_RESET_ADDRESS = 64'h8000_0000
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  cf_valid,
    input  logic                  cf_ack,
    input  logic [XLEN-1:0]       cf_target,
    input  logic                  s1_valid,
    input  logic [FD_IBUF_R-1:0]  s1_instr,
    input  logic [FD_ERR_R-1:0]   s1_ferr,
    output logic                  s2_eat_2,
    output logic                  s2_eat_4,
    output logic                  s2_valid,
    input  logic                  s2_ready,
    output logic [XLEN-1:0]       s2_pc,
    output logic [FD_IBUF_R-1:0]  s2_instr,
    output logic                  s2_size32,
    output logic [REG_ADDR_R-1:0] s2_rs1,
    output logic [REG_ADDR_R-1:0] s2_rs2,
    output logic [REG_ADDR_R-1:0] s2_rd,
    output logic                  s2_trap_ferr,
    output logic                  s2_trap_ill
);

    logic                  is32;
    logic [REG_ADDR_R-1:0] f_rs1;
    logic [REG_ADDR_R-1:0] f_rs2;
    logic [REG_ADDR_R-1:0] f_rd;
    logic                  f_trap_ferr;
    logic                  f_trap_ill;

    logic                  e_cf;
    logic                  s2_free;
    logic                  accept;
    logic [XLEN-1:0]       pc_r;
    logic [XLEN-1:0]       pc_step;
    dec_t                  dec_d;
    dec_t                  s2_q;
    logic [XLEN-1:0]       s2_pc_q;

    core_pipe_decode_fields u_fields (
        .s1_instr  (s1_instr),
        .s1_ferr   (s1_ferr),
        .is32      (is32),
        .rs1       (f_rs1),
        .rs2       (f_rs2),
        .rd        (f_rd),
        .trap_ferr (f_trap_ferr),
        .trap_ill  (f_trap_ill)
    );

    // Handshake: a control-flow change always wins, and nothing is taken while in reset
    always_comb begin
        e_cf     = cf_valid && cf_ack;
        s2_free  = !s2_valid || s2_ready;
        accept   = g_resetn && s1_valid && s2_free && !e_cf;
        s2_eat_4 = accept && is32;
        s2_eat_2 = accept && !is32;
        pc_step  = is32 ? XLEN'(4) : XLEN'(2);
    end

    // Assemble the payload that loads into s2 on accept
    always_comb begin
        dec_d           = '0;
        dec_d.instr     = is32 ? s1_instr : {16'h0000, s1_instr[15:0]};
        dec_d.size32    = is32;
        dec_d.rs1       = f_rs1;
        dec_d.rs2       = f_rs2;
        dec_d.rd        = f_rd;
        dec_d.trap_ferr = f_trap_ferr;
        dec_d.trap_ill  = f_trap_ill;
    end

    // Architectural fetch PC: retarget on control flow, advance by instruction size on accept
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            pc_r <= PC_RESET_ADDRESS;
        end else if (e_cf) begin
            pc_r <= cf_target;
        end else if (accept) begin
            pc_r <= pc_r + pc_step;
        end
    end

    // s2 pipeline register: flush beats ready, payload holds while stalled
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
            s2_pc_q  <= '0;
        end else if (e_cf) begin
            s2_valid <= 1'b0;
        end else if (accept) begin
            s2_valid <= 1'b1;
            s2_q     <= dec_d;
            s2_pc_q  <= pc_r;
        end else if (s2_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign s2_pc        = s2_pc_q;
    assign s2_instr     = s2_q.instr;
    assign s2_size32    = s2_q.size32;
    assign s2_rs1       = s2_q.rs1;
    assign s2_rs2       = s2_q.rs2;
    assign s2_rd        = s2_q.rd;
    assign s2_trap_ferr = s2_q.trap_ferr;
    assign s2_trap_ill  = s2_q.trap_ill;

endmodule

// File: tb/tb_core_pipe_decode.sv
// Scoreboard bench for core_pipe_decode: directed scenarios then randomized traffic.
// Driver updates inputs on negedge, checks eats and pushes expectations at +2.
// Monitor compares the s2 register against the queue front at +3 of each cycle.
module tb_core_pipe_decode;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        cf_valid = 1'b0;
    logic        cf_ack = 1'b0;
    logic [63:0] cf_target = '0;
    logic        s1_valid = 1'b0;
    logic [31:0] s1_instr = '0;
    logic [1:0]  s1_ferr = '0;
    logic        s2_eat_2;
    logic        s2_eat_4;
    logic        s2_valid;
    logic        s2_ready = 1'b0;
    logic [63:0] s2_pc;
    logic [31:0] s2_instr;
    logic        s2_size32;
    logic [4:0]  s2_rs1;
    logic [4:0]  s2_rs2;
    logic [4:0]  s2_rd;
    logic        s2_trap_ferr;
    logic        s2_trap_ill;

    core_pipe_decode #(.XLEN(64), .PC_RESET_ADDRESS(64'h8000_0000)) dut (
        .g_clk        (g_clk),
        .g_resetn     (g_resetn),
        .cf_valid     (cf_valid),
        .cf_ack       (cf_ack),
        .cf_target    (cf_target),
        .s1_valid     (s1_valid),
        .s1_instr     (s1_instr),
        .s1_ferr      (s1_ferr),
        .s2_eat_2     (s2_eat_2),
        .s2_eat_4     (s2_eat_4),
        .s2_valid     (s2_valid),
        .s2_ready     (s2_ready),
        .s2_pc        (s2_pc),
        .s2_instr     (s2_instr),
        .s2_size32    (s2_size32),
        .s2_rs1       (s2_rs1),
        .s2_rs2       (s2_rs2),
        .s2_rd        (s2_rd),
        .s2_trap_ferr (s2_trap_ferr),
        .s2_trap_ill  (s2_trap_ill)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        size32;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        tf;
        logic        ti;
    } exp_t;

    exp_t            q[$];
    int              pre_size = 0;
    bit              cf_now = 1'b0;
    longint unsigned m_pc = RST_PC;
    int              checks = 0;
    int              errors = 0;

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode straight from the ISA rules
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [1:0] fe, input logic [63:0] pc);
        exp_t e;
        e.pc     = pc;
        e.size32 = (w[1:0] == 2'b11) && !fe[0];
        if (e.size32) begin
            e.instr = w;
            e.rd    = w[11:7];
            e.rs1   = w[19:15];
            e.rs2   = w[24:20];
            e.tf    = (fe != 2'b00);
            e.ti    = !(w[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h2F,
                                       7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73});
        end else begin
            e.instr = {16'h0000, w[15:0]};
            e.tf    = fe[0];
            e.ti    = (w[15:0] == 16'h0000);
            if (w[1:0] == 2'b10) begin
                e.rd  = w[11:7];
                e.rs1 = w[11:7];
                e.rs2 = w[6:2];
            end else begin
                e.rd  = 5'd8 + 5'(w[9:7]);
                e.rs1 = e.rd;
                e.rs2 = 5'd8 + 5'(w[4:2]);
            end
        end
        if (e.tf) e.ti = 1'b0;
        return e;
    endfunction

    // One clock of stimulus plus the model's view of that cycle
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [1:0] fe,
                         input bit rdy, input bit cv, input bit ca, input logic [63:0] tgt);
        exp_t e;
        bit   ecf;
        bit   acc;
        @(negedge g_clk);
        s1_valid  = v;
        s1_instr  = ins;
        s1_ferr   = fe;
        s2_ready  = rdy;
        cf_valid  = cv;
        cf_ack    = ca;
        cf_target = tgt;
        #2;
        ecf = cv && ca;
        acc = v && ((q.size() == 0) || rdy) && !ecf;
        e   = ref_dec(ins, fe, m_pc);
        check1("eat_4", {63'd0, s2_eat_4}, {63'd0, acc && e.size32});
        check1("eat_2", {63'd0, s2_eat_2}, {63'd0, acc && !e.size32});
        pre_size = q.size();
        cf_now   = ecf;
        if (ecf) begin
            q.delete();
            m_pc = tgt;
        end else if (acc) begin
            q.push_back(e);
            m_pc = m_pc + (e.size32 ? 64'd4 : 64'd2);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [1:0] fe, input bit rdy);
        cycle(1'b1, ins, fe, rdy, 1'b0, 1'b0, 64'h0);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock
    task automatic do_reset();
        @(negedge g_clk);
        #1 g_resetn = 1'b0;
        #1;
        check1("rst_valid", {63'd0, s2_valid}, 64'd0);
        check1("rst_eat_2", {63'd0, s2_eat_2}, 64'd0);
        check1("rst_eat_4", {63'd0, s2_eat_4}, 64'd0);
        check1("rst_pc", s2_pc, 64'd0);
        check1("rst_instr", {32'd0, s2_instr}, 64'd0);
        check1("rst_rd", {59'd0, s2_rd}, 64'd0);
        q.delete();
        m_pc     = RST_PC;
        pre_size = 0;
        cf_now   = 1'b0;
        repeat (2) @(negedge g_clk);
        s1_valid = 1'b0;
        cf_valid = 1'b0;
        cf_ack   = 1'b0;
        s2_ready = 1'b1;
        g_resetn = 1'b1;
    endtask

    // Monitor: s2 occupancy and payload against the scoreboard front
    initial begin
        exp_t f;
        forever begin
            @(negedge g_clk);
            #3;
            if (g_resetn) begin
                check1("s2_valid", {63'd0, s2_valid}, {63'd0, pre_size > 0});
                if (s2_valid && (pre_size > 0) && !cf_now && (q.size() > 0)) begin
                    f = q[0];
                    check1("s2_pc", s2_pc, f.pc);
                    check1("s2_instr", {32'd0, s2_instr}, {32'd0, f.instr});
                    check1("s2_size32", {63'd0, s2_size32}, {63'd0, f.size32});
                    check1("s2_regs", {49'd0, s2_rs1, s2_rs2, s2_rd}, {49'd0, f.rs1, f.rs2, f.rd});
                    check1("s2_traps", {62'd0, s2_trap_ferr, s2_trap_ill}, {62'd0, f.tf, f.ti});
                    if (s2_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    logic [6:0] legal_opc [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h2F,
                                   7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    initial begin
        logic [31:0] w;
        logic [1:0]  fe;
        bit          cv;

        // power-on reset, then release
        do_reset();

        // addi x1,x0,10 straight after reset
        issue(32'h00A0_0093, 2'b00, 1'b1);
        // 16-bit c.li then a 32-bit op; upper half of the 16-bit window is junk
        issue(32'hFFFF_4501, 2'b00, 1'b1);
        issue(32'h0020_81B3, 2'b00, 1'b1);
        cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);

        // stall for three cycles with fetch presenting, then release
        issue(32'h0041_0113, 2'b00, 1'b1);
        repeat (3) issue(32'h0000_8082, 2'b00, 1'b0);
        issue(32'h0000_8082, 2'b00, 1'b1);
        cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);

        // control-flow change with s1 and s2 both valid
        issue(32'h0000_0013, 2'b00, 1'b0);
        cycle(1'b1, 32'h0000_0013, 2'b00, 1'b1, 1'b1, 1'b1, 64'h8000_1002);
        issue(32'h00A0_0093, 2'b00, 1'b1);
        // cf_valid without ack changes nothing
        cycle(1'b1, 32'h0000_4505, 2'b00, 1'b1, 1'b1, 1'b0, 64'h1234_5678);

        // trap cases
        issue(32'h00A0_0093, 2'b10, 1'b1);
        issue(32'h00A0_0093, 2'b01, 1'b1);
        issue(32'h0000_0000, 2'b00, 1'b1);
        issue(32'h0000_007F, 2'b00, 1'b1);
        issue(32'hDEAD_0000, 2'b01, 1'b1);
        cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       w = {$urandom_range(0, 32'h01FF_FFFF), legal_opc[$urandom_range(0, 13)]};
                1:       w = {16'($urandom), 14'($urandom), 2'($urandom_range(0, 2))};
                2:       w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                default: w = $urandom;
            endcase
            fe = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            cv = ($urandom_range(0, 15) == 0);
            cycle(($urandom_range(0, 3) != 0), w, fe, ($urandom_range(0, 3) != 0),
                  cv, cv && ($urandom_range(0, 1) == 1),
                  {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE);
            if (i == 300) begin
                // reset in the middle of traffic; fetch restarts from the reset PC
                do_reset();
                issue(32'h00A0_0093, 2'b00, 1'b1);
            end
        end

        // drain: everything pushed must have come out
        repeat (4) cycle(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 64'h0);
        check1("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
